pipearch_dma_read_mux: RTL and testbench
========================================

// Module: pipearch_dma_read_mux
// PURPOSE
//  Shares one DMA read port among N_CH engine read clients, e.g. several GLM pipelines behind one CCI-P c0 read channel.
//  Each client posts a burst (base address + line count); the block splits it into single-line requests.
//  Requests are arbitrated round-robin onto the shared port, and returned lines are routed back to the owning client by tag.
//  Sits between the engine tops and pipearch_dma_read; it generalises the single-engine read path to N channels.
// PARAMETERS
//  N_CH      4    number of client channels (>=2)
//  ADDR_W    42   cache-line address width
//  LEN_W     32   burst length width, in lines
//  DATA_W    512  line width
//  MAX_OUT   64   max outstanding lines per channel (power of 2)
//  CH_W      $clog2(N_CH), derived   channel-id bits in tag
//  TAG_W     16   mdata/tag width; must be >= CH_W
// PORTS
//  clk            in   1               clock
//  reset          in   1               async active-high reset
//  ch_req_valid   in   N_CH            client burst request valid
//  ch_req_ready   out  N_CH            client may post a burst (channel idle)
//  ch_req_addr    in   N_CH x ADDR_W   burst base line address
//  ch_req_lines   in   N_CH x LEN_W    burst length in lines
//  ch_busy        out  N_CH            burst in progress or lines outstanding
//  ch_rsp_valid   out  N_CH            one-hot: line returned to channel
//  ch_rsp_data    out  DATA_W          returned line (shared bus)
//  mem_req_valid  out  1               shared-port line request
//  mem_req_addr   out  ADDR_W          line address
//  mem_req_tag    out  TAG_W           {channel id, zero-padding}, channel id in the MSBs
//  mem_almfull    in   1               shared port almost full; hard stall on new grants
//  mem_rsp_valid  in   1               line returned
//  mem_rsp_tag    in   TAG_W           tag of returned line
//  mem_rsp_data   in   DATA_W          returned data
//  err_unexpected out  1               sticky: response for a channel with zero outstanding
// BEHAVIOUR
//  Clock/reset: single clock clk; reset is asynchronous and active-high.
//  Reset values: every output is 0 except ch_req_ready, which is all-ones. All counters and FSMs clear.
//  Per-channel FSM, IDLE -> ISSUE -> DRAIN -> IDLE:
//   - IDLE: ch_req_ready=1. On valid&&ready, latch addr and lines.
//     lines==0: stay in IDLE, no request issued. Otherwise go to ISSUE with busy=1 from the next cycle.
//   - ISSUE: the channel is eligible when remaining>0 && outstanding<MAX_OUT.
//     On grant: addr+=1 (wraps modulo 2^ADDR_W), remaining-=1. At remaining==0 go to DRAIN.
//   - DRAIN: go to IDLE once outstanding==0; busy drops on the same edge.
//  Arbitration:
//   - At most one grant per cycle, only when !mem_almfull.
//   - Round-robin; the pointer advances to the channel after the winner.
//   - mem_req_valid, addr and tag are registered: 1 cycle after grant.
//  Outstanding counter (per channel):
//   - +1 on grant, -1 on a response whose tag MSBs equal the channel.
//   - Grant and response in the same cycle: net 0.
//   - Counter never exceeds MAX_OUT.
//  Response routing:
//   - ch_rsp_valid and ch_rsp_data are registered: 1-cycle latency, in arrival order, no reordering.
//   - Tag channel >= N_CH, or channel outstanding==0: response dropped and err_unexpected set (cleared only by reset).
//  Reset mid-operation: in-flight lines are forgotten. Responses arriving after reset hit outstanding==0 and flag the error.
// CONFIGURATION
//  PIPEARCH_RD_MUX_STATS_EN defined:
//   - Adds outputs stat_req_lines and stat_rsp_lines (N_CH x 32 each).
//   - Per-channel counters of granted and delivered lines; they wrap, clear on reset, and are not cleared between bursts.
//  Undefined: the ports and counters are absent and behaviour is otherwise identical.
// STRUCTURE
//  - pipearch_common_pkg: t_ch_state enum (IDLE, ISSUE, DRAIN), t_rd_mux_tag packed struct, DMA line/addr typedefs.
//  - Sub-module pipearch_rr_arbiter #(N): req vector, enable -> one-hot grant; pointer update on enable&&|req.
//  - Top holds the per-channel FSM/counters in a generate loop, the output registers and the response demux.
// TESTING
//  - Ch0 burst addr=0x100 lines=4, others idle, no stall ->
//    mem_req addrs 0x100..0x103 on 4 consecutive cycles, tag ch=0;
//    4 responses return on ch_rsp_valid[0]; busy low after the last one.
//  - All 4 channels post lines=2 in the same cycle ->
//    grant order ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3.
//  - MAX_OUT=4, ch1 lines=8, responses withheld ->
//    exactly 4 requests, then stall; each response releases exactly one more request.
//  - mem_almfull held 10 cycles mid-burst ->
//    no mem_req_valid during the hold (beyond the 1 already registered); addresses resume contiguous.
//  - Response with tag ch=2 while ch2 idle ->
//    dropped, err_unexpected=1 and stays 1; lines=0 request -> no mem_req, ready stays 1.
//  - Async reset asserted mid-burst ->
//    all outputs reset immediately; late responses set err_unexpected only.

Source files
------------

// File: rtl/pipearch_common_pkg.sv
// -----------------------------------------------------------------------------
// pipearch_common_pkg
// Shared types for the pipearch DMA read path.
//   - DMA_ADDR_W / DMA_LINE_W : default cache-line address and line widths
//   - t_dma_addr / t_dma_line : line address and line data for the default geometry
//   - t_ch_state              : per-channel burst FSM state of the read mux
//   - t_rd_mux_tag            : read-mux tag layout, channel id in the MSBs
//                               (default geometry: 4 channels, 16-bit tag)
// No ports; imported with `import pipearch_common_pkg::*;`.
// -----------------------------------------------------------------------------
package pipearch_common_pkg;

    localparam int DMA_ADDR_W    = 42;
    localparam int DMA_LINE_W    = 512;
    localparam int RD_MUX_TAG_W  = 16;
    localparam int RD_MUX_CH_W   = 2;

    typedef logic [DMA_ADDR_W-1:0] t_dma_addr;
    typedef logic [DMA_LINE_W-1:0] t_dma_line;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ISSUE = 2'd1,
        CH_DRAIN = 2'd2
    } t_ch_state;

    typedef struct packed {
        logic [RD_MUX_CH_W-1:0]              ch;
        logic [RD_MUX_TAG_W-RD_MUX_CH_W-1:0] pad;
    } t_rd_mux_tag;

endpackage

// File: rtl/pipearch_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pipearch_rr_arbiter
// Round-robin arbiter producing at most one one-hot grant per cycle.
// The search starts at the pointer; after a grant the pointer moves to the
// channel following the winner, so every requester is served in turn.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   req   [N]  : request vector
//   en         : grants allowed this cycle
//   grant [N]  : one-hot grant (all zero when !en or no request)
// -----------------------------------------------------------------------------
module pipearch_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                if (en) begin
                    grant[idx] = 1'b1;
                    ptr_d      = PTR_W'((int'(idx) + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pipearch_dma_read_mux.sv
// -----------------------------------------------------------------------------
// pipearch_dma_read_mux
// Shares one DMA read port among N_CH read clients. Each client posts a burst
// (base line address + line count); the burst is split into single-line
// requests, arbitrated round-robin onto the shared port, and returned lines
// are routed back to the owning client by the channel id in the tag MSBs.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   ch_req_valid/ready/addr/lines   per-channel burst post (ready = idle)
//   ch_busy          burst in progress or lines outstanding
//   ch_rsp_valid     one-hot returned-line strobe, ch_rsp_data shared bus
//   mem_req_valid/addr/tag          registered shared-port line request
//   mem_almfull      blocks new grants while high
//   mem_rsp_valid/tag/data          returned line from the shared port
//   err_unexpected   sticky: response for an unknown or idle channel
//   stat_req_lines / stat_rsp_lines (only with PIPEARCH_RD_MUX_STATS_EN):
//                    per-channel wrapping counts of granted / delivered lines
//
// Optional feature macro: PIPEARCH_RD_MUX_STATS_EN
// -----------------------------------------------------------------------------
module pipearch_dma_read_mux
    import pipearch_common_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int ADDR_W  = DMA_ADDR_W,
    parameter int LEN_W   = 32,
    parameter int DATA_W  = DMA_LINE_W,
    parameter int MAX_OUT = 64,
    parameter int TAG_W   = RD_MUX_TAG_W
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef PIPEARCH_RD_MUX_STATS_EN
    output logic [N_CH-1:0][31:0]        stat_req_lines,
    output logic [N_CH-1:0][31:0]        stat_rsp_lines,
`endif
    input  logic [N_CH-1:0]              ch_req_valid,
    output logic [N_CH-1:0]              ch_req_ready,
    input  logic [N_CH-1:0][ADDR_W-1:0]  ch_req_addr,
    input  logic [N_CH-1:0][LEN_W-1:0]   ch_req_lines,
    output logic [N_CH-1:0]              ch_busy,
    output logic [N_CH-1:0]              ch_rsp_valid,
    output logic [DATA_W-1:0]            ch_rsp_data,
    output logic                         mem_req_valid,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [TAG_W-1:0]             mem_req_tag,
    input  logic                         mem_almfull,
    input  logic                         mem_rsp_valid,
    input  logic [TAG_W-1:0]             mem_rsp_tag,
    input  logic [DATA_W-1:0]            mem_rsp_data,
    output logic                         err_unexpected
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int OUT_W = $clog2(MAX_OUT) + 1;

    logic [N_CH-1:0]   elig;
    logic [N_CH-1:0]   grant;
    logic [N_CH-1:0]   rsp_hit;
    logic [N_CH-1:0]   out_nz;
    logic [ADDR_W-1:0] ch_addr [N_CH];
    logic [CH_W-1:0]   rsp_ch;
    logic [CH_W-1:0]   win;

    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_req_addr_q,  mem_req_addr_d;
    logic [TAG_W-1:0]  mem_req_tag_q,   mem_req_tag_d;
    logic [N_CH-1:0]   ch_rsp_valid_q,  ch_rsp_valid_d;
    logic [DATA_W-1:0] ch_rsp_data_q,   ch_rsp_data_d;
    logic              err_q,           err_d;

    assign rsp_ch = mem_rsp_tag[TAG_W-1 -: CH_W];

    // Only the channel-id field of a returned tag matters; the padding is ignored.
    if (TAG_W > CH_W) begin : g_tag_pad
        logic unused_tag_pad;
        assign unused_tag_pad = ^mem_rsp_tag[TAG_W-CH_W-1:0];
    end

    pipearch_rr_arbiter #(
        .N (N_CH)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (elig),
        .en    (!mem_almfull),
        .grant (grant)
    );

    // A response is accepted only if its channel exists and has a line in
    // flight; with a non-power-of-2 N_CH an out-of-range id matches no channel.
    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (mem_rsp_valid && (rsp_ch == CH_W'(i)) && out_nz[i]) begin
                rsp_hit[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        t_ch_state         state_q, state_d;
        logic [ADDR_W-1:0] addr_q,  addr_d;
        logic [LEN_W-1:0]  rem_q,   rem_d;
        logic [OUT_W-1:0]  out_q,   out_d;

        always_comb begin
            state_d = state_q;
            addr_d  = addr_q;
            rem_d   = rem_q;
            out_d   = out_q;
            unique case (state_q)
                CH_IDLE: begin
                    if (ch_req_valid[g]) begin
                        addr_d = ch_req_addr[g];
                        rem_d  = ch_req_lines[g];
                        // Zero-length bursts are consumed without leaving IDLE.
                        if (ch_req_lines[g] != '0) begin
                            state_d = CH_ISSUE;
                        end
                    end
                end
                CH_ISSUE: begin
                    if (grant[g]) begin
                        addr_d = addr_q + ADDR_W'(1);
                        rem_d  = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_d = CH_DRAIN;
                        end
                    end
                end
                CH_DRAIN: begin
                    if (out_q == '0) begin
                        state_d = CH_IDLE;
                    end
                end
                default: state_d = CH_IDLE;
            endcase
            // Grant and accepted response in the same cycle cancel out.
            case ({grant[g], rsp_hit[g]})
                2'b10:   out_d = out_q + OUT_W'(1);
                2'b01:   out_d = out_q - OUT_W'(1);
                default: out_d = out_q;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= CH_IDLE;
                addr_q  <= '0;
                rem_q   <= '0;
                out_q   <= '0;
            end else begin
                state_q <= state_d;
                addr_q  <= addr_d;
                rem_q   <= rem_d;
                out_q   <= out_d;
            end
        end

        assign elig[g]         = (state_q == CH_ISSUE) && (rem_q != '0) &&
                                 (out_q < OUT_W'(MAX_OUT));
        assign out_nz[g]       = (out_q != '0);
        assign ch_addr[g]      = addr_q;
        assign ch_req_ready[g] = (state_q == CH_IDLE);
        assign ch_busy[g]      = (state_q != CH_IDLE);

`ifdef PIPEARCH_RD_MUX_STATS_EN
        logic [31:0] stat_req_q, stat_req_d;
        logic [31:0] stat_rsp_q, stat_rsp_d;

        always_comb begin
            stat_req_d = stat_req_q + (grant[g]   ? 32'd1 : 32'd0);
            stat_rsp_d = stat_rsp_q + (rsp_hit[g] ? 32'd1 : 32'd0);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stat_req_q <= '0;
                stat_rsp_q <= '0;
            end else begin
                stat_req_q <= stat_req_d;
                stat_rsp_q <= stat_rsp_d;
            end
        end

        assign stat_req_lines[g] = stat_req_q;
        assign stat_rsp_lines[g] = stat_rsp_q;
`endif
    end

    always_comb begin
        win = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                win = CH_W'(i);
            end
        end
    end

    always_comb begin
        mem_req_valid_d = |grant;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_tag_d   = mem_req_tag_q;
        if (|grant) begin
            mem_req_addr_d = ch_addr[win];
            mem_req_tag_d  = TAG_W'(win) << (TAG_W - CH_W);
        end
        ch_rsp_valid_d = rsp_hit;
        ch_rsp_data_d  = mem_rsp_valid ? mem_rsp_data : ch_rsp_data_q;
        err_d          = err_q | (mem_rsp_valid && (rsp_hit == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_tag_q   <= '0;
            ch_rsp_valid_q  <= '0;
            ch_rsp_data_q   <= '0;
            err_q           <= 1'b0;
        end else begin
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_tag_q   <= mem_req_tag_d;
            ch_rsp_valid_q  <= ch_rsp_valid_d;
            ch_rsp_data_q   <= ch_rsp_data_d;
            err_q           <= err_d;
        end
    end

    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_addr   = mem_req_addr_q;
    assign mem_req_tag    = mem_req_tag_q;
    assign ch_rsp_valid   = ch_rsp_valid_q;
    assign ch_rsp_data    = ch_rsp_data_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_pipearch_dma_read_mux.sv
module tb_pipearch_dma_read_mux;

    localparam int N_CH    = 4;
    localparam int ADDR_W  = 42;
    localparam int LEN_W   = 32;
    localparam int DATA_W  = 512;
    localparam int MAX_OUT = 4;
    localparam int TAG_W   = 16;

    logic                        clk;
    logic                        reset;
    logic [N_CH-1:0]             ch_req_valid;
    logic [N_CH-1:0]             ch_req_ready;
    logic [N_CH-1:0][ADDR_W-1:0] ch_req_addr;
    logic [N_CH-1:0][LEN_W-1:0]  ch_req_lines;
    logic [N_CH-1:0]             ch_busy;
    logic [N_CH-1:0]             ch_rsp_valid;
    logic [DATA_W-1:0]           ch_rsp_data;
    logic                        mem_req_valid;
    logic [ADDR_W-1:0]           mem_req_addr;
    logic [TAG_W-1:0]            mem_req_tag;
    logic                        mem_almfull;
    logic                        mem_rsp_valid;
    logic [TAG_W-1:0]            mem_rsp_tag;
    logic [DATA_W-1:0]           mem_rsp_data;
    logic                        err_unexpected;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [ADDR_W-1:0] q_addr [$];
    logic [TAG_W-1:0]  q_tag  [$];
    int                q_cyc  [$];

    pipearch_dma_read_mux #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
        .MAX_OUT(MAX_OUT), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_req_addr(ch_req_addr), .ch_req_lines(ch_req_lines),
        .ch_busy(ch_busy), .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_almfull(mem_almfull), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_data(mem_rsp_data),
        .err_unexpected(err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Request monitor: records every shared-port request shortly after the edge.
    always begin
        @(posedge clk);
        #2;
        if (mem_req_valid === 1'b1) begin
            q_addr.push_back(mem_req_addr);
            q_tag.push_back(mem_req_tag);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ch_req_valid  = '0;
        ch_req_addr   = '0;
        ch_req_lines  = '0;
        mem_almfull   = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_tag   = '0;
        mem_rsp_data  = '0;
    endtask

    task automatic clear_queue();
        q_addr.delete();
        q_tag.delete();
        q_cyc.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_queue();
    endtask

    task automatic wait_reqs(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && q_addr.size() < n; i++) @(negedge clk);
    endtask

    task automatic post(input int ch, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
        ch_req_valid[ch] = 1'b1;
        ch_req_addr[ch]  = a;
        ch_req_lines[ch] = n;
        @(negedge clk);
        ch_req_valid[ch] = 1'b0;
    endtask

    task automatic rsp_one(input int ch, input logic [DATA_W-1:0] d);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = TAG_W'(ch) << (TAG_W - 2);
        mem_rsp_data  = d;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        checks++; if (ch_req_ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %h exp f", ch_req_ready); end
        checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h exp 0", ch_busy); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b exp 0", mem_req_valid); end
        checks++; if (mem_req_addr !== '0) begin errors++; $display("FAIL reset_mem_req_addr: got %h exp 0", mem_req_addr); end
        checks++; if (mem_req_tag !== '0) begin errors++; $display("FAIL reset_mem_req_tag: got %h exp 0", mem_req_tag); end
        checks++; if (ch_rsp_valid !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid: got %h exp 0", ch_rsp_valid); end
        checks++; if (ch_rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h exp 0", ch_rsp_data); end
        checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_unexpected); end
        reset = 1'b0;
        clear_queue();
    endtask

    task automatic test_single_burst();
        logic [DATA_W-1:0] d;
        apply_reset();
        post(0, 42'h100, 32'd4);
        checks++; if (ch_busy !== 4'b0001) begin errors++; $display("FAIL single_busy_start: got %h exp 1", ch_busy); end
        checks++; if (ch_req_ready !== 4'b1110) begin errors++; $display("FAIL single_ready_start: got %h exp e", ch_req_ready); end
        wait_reqs(4, 20);
        repeat (3) @(negedge clk);
        checks++; if (q_addr.size() != 4) begin errors++; $display("FAIL single_req_count: got %0d exp 4", q_addr.size()); end
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== ADDR_W'(32'h100 + i)) begin errors++; $display("FAIL single_addr[%0d]: got %h exp %h", i, q_addr[i], 32'h100 + i); end
            checks++; if (q_tag[i] !== 16'h0000) begin errors++; $display("FAIL single_tag[%0d]: got %h exp 0000", i, q_tag[i]); end
            checks++; if (q_cyc[i] != q_cyc[0] + i) begin errors++; $display("FAIL single_consecutive[%0d]: got cycle %0d exp %0d", i, q_cyc[i], q_cyc[0] + i); end
        end
        for (int k = 0; k < 4; k++) begin
            d = {16{32'hA500_0000 + 32'(k)}};
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = 16'h0000;
            mem_rsp_data  = d;
            @(negedge clk);
            checks++; if (ch_rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid[%0d]: got %h exp 1", k, ch_rsp_valid); end
            checks++; if (ch_rsp_data !== d) begin errors++; $display("FAIL single_rsp_data[%0d]: got %h exp %h", k, ch_rsp_data[31:0], d[31:0]); end
        end
        mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL single_busy_end: got %h exp 0", ch_busy); end
        checks++; if (ch_req_ready !== 4'hF) begin errors++; $display("FAIL single_ready_end: got %h exp f", ch_req_ready); end
        checks++; if (ch_rsp_valid !== 4'h0) begin errors++; $display("FAIL single_rsp_idle: got %h exp 0", ch_rsp_valid); end
        checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", err_unexpected); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int c = 0; c < N_CH; c++) begin
            ch_req_valid[c] = 1'b1;
            ch_req_addr[c]  = ADDR_W'(32'h1000 * (c + 1));
            ch_req_lines[c] = 32'd2;
        end
        @(negedge clk);
        ch_req_valid = '0;
        wait_reqs(8, 30);
        repeat (3) @(negedge clk);
        checks++; if (q_addr.size() != 8) begin errors++; $display("FAIL rr_req_count: got %0d exp 8", q_addr.size()); end
        for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
            checks++; if (q_tag[i] !== TAG_W'(i % 4) << 14) begin errors++; $display("FAIL rr_tag[%0d]: got %h exp %h", i, q_tag[i], TAG_W'(i % 4) << 14); end
            checks++; if (q_addr[i] !== ADDR_W'(32'h1000 * ((i % 4) + 1) + i / 4)) begin errors++; $display("FAIL rr_addr[%0d]: got %h exp %h", i, q_addr[i], 32'h1000 * ((i % 4) + 1) + i / 4); end
        end
        for (int i = 0; i < 8; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = TAG_W'(i % 4) << 14;
            mem_rsp_data  = DATA_W'(32'hBEE0 + i);
            @(negedge clk);
            checks++; if (ch_rsp_valid !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_route[%0d]: got %h exp %h", i, ch_rsp_valid, 4'(1 << (i % 4))); end
        end
        mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL rr_busy_end: got %h exp 0", ch_busy); end
        checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL rr_err: got %b exp 0", err_unexpected); end
    endtask

    task automatic test_max_outstanding();
        apply_reset();
        post(1, 42'h200, 32'd8);
        repeat (12) @(negedge clk);
        checks++; if (q_addr.size() != 4) begin errors++; $display("FAIL maxout_stall: got %0d requests exp 4", q_addr.size()); end
        checks++; if (ch_busy !== 4'b0010) begin errors++; $display("FAIL maxout_busy: got %h exp 2", ch_busy); end
        for (int k = 0; k < 4; k++) begin
            rsp_one(1, DATA_W'(k));
            repeat (6) @(negedge clk);
            checks++; if (q_addr.size() != 5 + k) begin errors++; $display("FAIL maxout_release[%0d]: got %0d requests exp %0d", k, q_addr.size(), 5 + k); end
        end
        for (int k = 0; k < 4; k++) rsp_one(1, DATA_W'(k + 4));
        repeat (3) @(negedge clk);
        checks++; if (q_addr.size() != 8) begin errors++; $display("FAIL maxout_total: got %0d exp 8", q_addr.size()); end
        for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== ADDR_W'(32'h200 + i)) begin errors++; $display("FAIL maxout_addr[%0d]: got %h exp %h", i, q_addr[i], 32'h200 + i); end
        end
        checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL maxout_busy_end: got %h exp 0", ch_busy); end
        checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL maxout_err: got %b exp 0", err_unexpected); end
    endtask

    task automatic test_almfull();
        apply_reset();
        post(2, 42'h3F0, 32'd4);
        wait_reqs(1, 10);
        mem_almfull = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (q_addr.size() != 1) begin errors++; $display("FAIL almfull_hold: got %0d requests exp 1", q_addr.size()); end
        mem_almfull = 1'b0;
        wait_reqs(4, 20);
        repeat (2) @(negedge clk);
        checks++; if (q_addr.size() != 4) begin errors++; $display("FAIL almfull_count: got %0d exp 4", q_addr.size()); end
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== ADDR_W'(32'h3F0 + i)) begin errors++; $display("FAIL almfull_addr[%0d]: got %h exp %h", i, q_addr[i], 32'h3F0 + i); end
            checks++; if (q_tag[i] !== 16'h8000) begin errors++; $display("FAIL almfull_tag[%0d]: got %h exp 8000", i, q_tag[i]); end
        end
    endtask

    task automatic test_addr_wrap();
        logic [ADDR_W-1:0] base;
        base = 42'h3FF_FFFF_FFFE;
        apply_reset();
        post(0, base, 32'd3);
        wait_reqs(3, 20);
        repeat (2) @(negedge clk);
        checks++; if (q_addr.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d exp 3", q_addr.size()); end
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== base + ADDR_W'(i)) begin errors++; $display("FAIL wrap_addr[%0d]: got %h exp %h", i, q_addr[i], base + ADDR_W'(i)); end
        end
    endtask

    task automatic test_unexpected_rsp();
        apply_reset();
        rsp_one(2, DATA_W'(32'hDEAD));
        checks++; if (ch_rsp_valid !== 4'h0) begin errors++; $display("FAIL unexp_dropped: got %h exp 0", ch_rsp_valid); end
        checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_err_set: got %b exp 1", err_unexpected); end
        repeat (5) @(negedge clk);
        checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_err_sticky: got %b exp 1", err_unexpected); end
        post(3, 42'h700, 32'd0);
        checks++; if (ch_req_ready[3] !== 1'b1) begin errors++; $display("FAIL zero_len_ready: got %b exp 1", ch_req_ready[3]); end
        repeat (8) @(negedge clk);
        checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL zero_len_no_req: got %0d requests exp 0", q_addr.size()); end
        checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL zero_len_busy: got %h exp 0", ch_busy); end
        checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL zero_len_err_kept: got %b exp 1", err_unexpected); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        post(0, 42'h500, 32'd4);
        wait_reqs(2, 20);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL async_mem_req_valid: got %b exp 0", mem_req_valid); end
        checks++; if (mem_req_addr !== '0) begin errors++; $display("FAIL async_mem_req_addr: got %h exp 0", mem_req_addr); end
        checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL async_busy: got %h exp 0", ch_busy); end
        checks++; if (ch_req_ready !== 4'hF) begin errors++; $display("FAIL async_ready: got %h exp f", ch_req_ready); end
        @(negedge clk);
        reset = 1'b0;
        clear_queue();
        rsp_one(0, DATA_W'(32'h1A7E));
        checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL async_late_err: got %b exp 1", err_unexpected); end
        checks++; if (ch_rsp_valid !== 4'h0) begin errors++; $display("FAIL async_late_dropped: got %h exp 0", ch_rsp_valid); end
        repeat (6) @(negedge clk);
        checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL async_no_resume: got %0d requests exp 0", q_addr.size()); end
        checks++; if (ch_busy !== 4'h0) begin errors++; $display("FAIL async_busy_after: got %h exp 0", ch_busy); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_outstanding();
        test_almfull();
        test_addr_wrap();
        test_unexpected_rsp();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
